// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared types and constants for the serializer slice.
// Holds the FSM state enum, the bit-counter width helper and the gap-counter width.
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        PARITY
    } state_e;

    localparam int GAP_CNT_W = 8;

    // Width of a counter that must hold WIDTH-1; never below one bit.
    function automatic int bit_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: valid/ready word handshake into the serializer.
// master (source): drives in_data/in_valid, sees in_ready; slave (serializer): the reverse.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/piso_gap_counter.sv
// piso_gap_counter: loadable down-counter with a zero flag for the inter-word gap.
// Ports: clk, reset (async, active-high), load/load_val, dec, zero (count == 0).
module piso_gap_counter
    import piso_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [GAP_CNT_W-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);

    logic [GAP_CNT_W-1:0] cnt_q;
    logic [GAP_CNT_W-1:0] cnt_d;

    // Saturates at zero so a stray decrement can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out word serializer, MSB first, valid/ready input.
// Ports: clk, reset (async, active-high), in_if (slave: in_data/in_valid/in_ready),
// serial_out, frame_active, done. WIDTH >= 2, GAP_CYCLES 0..255.
// Optional macro PISO_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    piso_serializer_if.slave       in_if,
    output logic                   serial_out,
    output logic                   frame_active,
    output logic                   done
);

    localparam int CNT_W = bit_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    // The gap counter runs GAP_CYCLES-1 .. 0, one state cycle per value.
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        HAS_GAP ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic             so_q;
    logic             so_d;
    logic             fa_q;
    logic             fa_d;
    logic             done_q;
    logic             done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par_q;
    logic             par_d;
`endif

    logic accept;
    logic ready;
    logic do_load;
    logic end_frame;
    logic gap_load;
    logic gap_dec;
    logic gap_zero;

    // done_q marks the final frame bit, which is also the only
    // non-idle cycle where a back-to-back word may be taken.
    assign ready = !reset &&
                   ((state_q == IDLE) || (!HAS_GAP && done_q));
    assign in_if.in_ready = ready;
    assign accept = in_if.in_valid && ready;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        so_d      = so_q;
        fa_d      = fa_q;
        done_d    = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_d     = par_q;
`endif
        do_load   = 1'b0;
        end_frame = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;

        unique case (state_q)
            IDLE: begin
                so_d    = 1'b0;
                fa_d    = 1'b0;
                do_load = accept;
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    sr_d      = sr_q << 1;
                    so_d      = sr_q[WIDTH-2];
                    bit_cnt_d = bit_cnt_q - 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                end else begin
                    state_d = PARITY;
                    so_d    = par_q;
                    done_d  = 1'b1;
                end
`else
                    done_d    = (bit_cnt_q == CNT_W'(1));
                end else begin
                    end_frame = 1'b1;
                end
`endif
            end
            PARITY: begin
                end_frame = 1'b1;
            end
            GAP: begin
                so_d = 1'b0;
                fa_d = 1'b0;
                if (gap_zero) begin
                    state_d = IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                so_d    = 1'b0;
                fa_d    = 1'b0;
            end
        endcase

        if (end_frame) begin
            if (HAS_GAP) begin
                state_d  = GAP;
                gap_load = 1'b1;
                so_d     = 1'b0;
                fa_d     = 1'b0;
            end else if (accept) begin
                do_load = 1'b1;
            end else begin
                state_d = IDLE;
                so_d    = 1'b0;
                fa_d    = 1'b0;
            end
        end

        if (do_load) begin
            state_d   = SHIFT;
            sr_d      = in_if.in_data;
            so_d      = in_if.in_data[WIDTH-1];
            fa_d      = 1'b1;
            bit_cnt_d = CNT_LOAD;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_d     = ^in_if.in_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            so_q      <= 1'b0;
            fa_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            so_q      <= so_d;
            fa_q      <= fa_d;
            done_q    <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    piso_gap_counter u_gap (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    assign serial_out   = so_q;
    assign frame_active = fa_q;
    assign done         = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of piso_serializer, GAP_CYCLES=0 and =2.
// Builds with or without PISO_SERIALIZER_PARITY_EN.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk;
    logic reset;
    logic so0, fa0, dn0;
    logic so1, fa1, dn1;

    piso_serializer_if #(.WIDTH(W)) if0 ();
    piso_serializer_if #(.WIDTH(W)) if1 ();

    piso_serializer #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .in_if        (if0),
        .serial_out   (so0),
        .frame_active (fa0),
        .done         (dn0)
    );

    piso_serializer #(.WIDTH(W), .GAP_CYCLES(2)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .in_if        (if1),
        .serial_out   (so1),
        .frame_active (fa1),
        .done         (dn1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] word;
        logic       par;
        logic [3:0] exp_rx;
    } vec_t;

    vec_t vecs [6];
    logic [3:0] rx;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [3:0] w, input logic p,
                                     input int j);
        if (j < W) return w[W-1-j];
        return p;
    endfunction

    task automatic chk_idle0(input string nm);
        check({nm, " so"}, int'(so0), 0);
        check({nm, " fa"}, int'(fa0), 0);
        check({nm, " done"}, int'(dn0), 0);
        check({nm, " ready"}, int'(if0.in_ready), 1);
    endtask

    // Single frame on dut0, starting from IDLE at a sample point.
    task automatic send_frame(input vec_t v);
        check("vec ready idle", int'(if0.in_ready), 1);
        if0.in_valid = 1'b1;
        if0.in_data  = v.word;
        cyc();
        if0.in_valid = 1'b0;
        rx = '0;
        for (int k = 0; k < FL; k++) begin
            check("vec bit", int'(so0), int'(exp_bit(v.word, v.par, k)));
            check("vec fa", int'(fa0), 1);
            check("vec done", int'(dn0), int'(k == FL - 1));
            check("vec ready", int'(if0.in_ready), int'(k == FL - 1));
            if (k < W) rx = {rx[2:0], so0};
            cyc();
        end
        chk_idle0("vec after");
        check("vec rx", int'(rx), int'(v.exp_rx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] wa;
        logic [3:0] wb;

        vecs[0] = '{4'b1011, 1'b1, 4'b1011};
        vecs[1] = '{4'b0001, 1'b1, 4'b0001};
        vecs[2] = '{4'b1000, 1'b1, 4'b1000};
        vecs[3] = '{4'b1111, 1'b0, 4'b1111};
        vecs[4] = '{4'b0110, 1'b0, 4'b0110};
        vecs[5] = '{4'b0111, 1'b1, 4'b0111};

        reset = 1'b1;
        if0.in_valid = 1'b0;
        if0.in_data  = '0;
        if1.in_valid = 1'b0;
        if1.in_data  = '0;

        #3;
        check("rst ready0", int'(if0.in_ready), 0);
        check("rst ready1", int'(if1.in_ready), 0);
        check("rst so", int'(so0), 0);
        check("rst fa", int'(fa0), 0);
        check("rst done", int'(dn0), 0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk_idle0("post rst");
        check("post rst ready1", int'(if1.in_ready), 1);

        foreach (vecs[i]) send_frame(vecs[i]);

        // Back-to-back: A then 5 with valid held, no bubble.
        wa = 4'hA;
        wb = 4'h5;
        if0.in_valid = 1'b1;
        if0.in_data  = wa;
        check("b2b ready idle", int'(if0.in_ready), 1);
        cyc();
        if0.in_data = wb;
        for (int k = 0; k < 2 * FL; k++) begin
            int j;
            j = k % FL;
            check("b2b bit", int'(so0),
                  int'(exp_bit((k < FL) ? wa : wb, 1'b0, j)));
            check("b2b fa", int'(fa0), 1);
            check("b2b done", int'(dn0), int'(j == FL - 1));
            check("b2b ready", int'(if0.in_ready), int'(j == FL - 1));
            if (k == FL) if0.in_valid = 1'b0;
            cyc();
        end
        chk_idle0("b2b after");

        // GAP_CYCLES=2: two words queued on dut1.
        if1.in_valid = 1'b1;
        if1.in_data  = wa;
        check("gap ready idle", int'(if1.in_ready), 1);
        cyc();
        if1.in_data = wb;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                check("gap bit", int'(so1),
                      int'(exp_bit((f == 0) ? wa : wb, 1'b0, k)));
                check("gap fa", int'(fa1), 1);
                check("gap done", int'(dn1), int'(k == FL - 1));
                check("gap ready", int'(if1.in_ready), 0);
                if (f == 1 && k == 0) if1.in_valid = 1'b0;
                cyc();
            end
            for (int g = 0; g < 2; g++) begin
                check("gap idle so", int'(so1), 0);
                check("gap idle fa", int'(fa1), 0);
                check("gap idle ready", int'(if1.in_ready), 0);
                cyc();
            end
            check("gap end ready", int'(if1.in_ready), 1);
            check("gap end fa", int'(fa1), 0);
            if (f == 0) cyc();
        end

        // Valid pulse mid-frame must be ignored.
        if0.in_valid = 1'b1;
        if0.in_data  = 4'h3;
        cyc();
        if0.in_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            check("ign bit", int'(so0), int'(exp_bit(4'h3, 1'b0, k)));
            if (k == 2) begin
                check("ign ready", int'(if0.in_ready), 0);
                if0.in_valid = 1'b1;
                if0.in_data  = 4'hF;
            end
            if (k == 3) if0.in_valid = 1'b0;
            cyc();
        end
        chk_idle0("ign after1");
        cyc();
        chk_idle0("ign after2");

        // Async reset mid-frame aborts with no done pulse.
        if0.in_valid = 1'b1;
        if0.in_data  = 4'h9;
        cyc();
        if0.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort bit", int'(so0), int'(exp_bit(4'h9, 1'b0, k)));
            if (k < 2) cyc();
        end
        #3;
        reset = 1'b1;
        #1;
        check("abort so", int'(so0), 0);
        check("abort fa", int'(fa0), 0);
        check("abort done", int'(dn0), 0);
        check("abort ready", int'(if0.in_ready), 0);
        @(posedge clk);
        #1;
        check("abort hold done", int'(dn0), 0);
        reset = 1'b0;
        #1;
        check("release ready", int'(if0.in_ready), 1);
        @(posedge clk);
        #1;
        chk_idle0("release cyc1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
